// File: rtl/ahb_bus_arbiter.sv
// Round-robin arbiter sharing one system bus between several masters and slaves.
// Each transfer runs IDLE -> GRANT (slave capture strobe) -> DATA (select until ready or timeout).
module ahb_bus_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int NUM_SLAVES     = 2,
   parameter int TIMEOUT_CYCLES = 16,
   localparam int OW            = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_MASTERS-1:0]    MReq,
   input  logic [NUM_MASTERS*32-1:0] MAddr,
   input  logic [NUM_MASTERS-1:0]    MWrite,
   input  logic [NUM_MASTERS*32-1:0] MWdata,
   output logic [NUM_MASTERS-1:0]    MGnt,
   output logic [NUM_MASTERS-1:0]    MDone,
   output logic [31:0]               MRdata,
   output logic [1:0]                MResp,
   output logic [OW-1:0]             Owner,
   output logic [31:0]               HAddress,
   output logic [31:0]               HWrite_data,
   output logic                      HWrite,
   output logic [NUM_SLAVES-1:0]     HGrant,
   output logic [NUM_SLAVES-1:0]     HSel,
   input  logic [NUM_SLAVES*32-1:0]  HRead_data,
   input  logic [NUM_SLAVES-1:0]     HReady,
   input  logic [NUM_SLAVES*2-1:0]   HResp
);

   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_DATA} state_e;

   state_e          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [OW-1:0]   ptr_q, ptr_d;
   logic [3:0]      slave_q, slave_d;
   logic            dec_err_q, dec_err_d;
   logic [TW-1:0]   tmo_q, tmo_d;

   logic [OW-1:0]          win;
   logic                   win_found;
   logic [3:0]             win_slave;
   logic [NUM_MASTERS-1:0] own_oh;
   logic [NUM_SLAVES-1:0]  sl_oh;
   logic [31:0]            own_addr, own_wdata;
   logic                   own_write;
   logic                   sl_ready;
   logic [31:0]            sl_rdata;
   logic [1:0]             sl_resp;
   logic                   tmo_hit;

   // Round-robin search: first requester above the pointer, else wrap to the lowest.
   always_comb begin
      win       = '0;
      win_found = 1'b0;
      for (int j = 0; j < NUM_MASTERS; j++) begin
         if (!win_found && MReq[j] && (OW'(j) > ptr_q)) begin
            win       = OW'(j);
            win_found = 1'b1;
         end
      end
      for (int j = 0; j < NUM_MASTERS; j++) begin
         if (!win_found && MReq[j] && (OW'(j) <= ptr_q)) begin
            win       = OW'(j);
            win_found = 1'b1;
         end
      end
      win_slave = '0;
      for (int j = 0; j < NUM_MASTERS; j++) begin
         if (OW'(j) == win) win_slave = MAddr[j*32+28 +: 4];
      end
   end

   always_comb begin
      own_oh    = '0;
      own_addr  = '0;
      own_wdata = '0;
      own_write = 1'b0;
      for (int j = 0; j < NUM_MASTERS; j++) begin
         if (OW'(j) == owner_q) begin
            own_oh[j] = 1'b1;
            own_addr  = MAddr[j*32 +: 32];
            own_wdata = MWdata[j*32 +: 32];
            own_write = MWrite[j];
         end
      end
   end

   always_comb begin
      sl_oh    = '0;
      sl_ready = 1'b0;
      sl_rdata = '0;
      sl_resp  = '0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
         if (slave_q == 4'(s)) begin
            sl_oh[s] = 1'b1;
            sl_ready = HReady[s];
            sl_rdata = HRead_data[s*32 +: 32];
            sl_resp  = HResp[s*2 +: 2];
         end
      end
   end

   // tmo_q counts earlier low-ready DATA cycles, so the abort lands on the TIMEOUT_CYCLES-th one.
   assign tmo_hit = (TIMEOUT_CYCLES > 0) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         owner_q   <= '0;
         ptr_q     <= OW'(NUM_MASTERS - 1);
         slave_q   <= '0;
         dec_err_q <= 1'b0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         slave_q   <= slave_d;
         dec_err_q <= dec_err_d;
         tmo_q     <= tmo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      slave_d   = slave_q;
      dec_err_d = dec_err_q;
      tmo_d     = tmo_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               owner_d   = win;
               ptr_d     = win;
               slave_d   = win_slave;
               dec_err_d = ({1'b0, win_slave} >= 5'(NUM_SLAVES));
               state_d   = ST_GRANT;
            end
         end
         ST_GRANT: begin
            tmo_d   = '0;
            state_d = dec_err_q ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (sl_ready || tmo_hit) begin
               state_d = ST_IDLE;
            end else if (TIMEOUT_CYCLES > 0) begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are forced low while rst is high so a reset mid-transfer never leaks a completion.
   always_comb begin
      MGnt        = '0;
      MDone       = '0;
      MRdata      = '0;
      MResp       = '0;
      HAddress    = '0;
      HWrite_data = '0;
      HWrite      = 1'b0;
      HGrant      = '0;
      HSel        = '0;
      if (!rst) begin
         case (state_q)
            ST_GRANT: begin
               MGnt        = own_oh;
               HAddress    = own_addr;
               HWrite_data = own_wdata;
               HWrite      = own_write;
               if (dec_err_q) begin
                  MDone = own_oh;
                  MResp = 2'b01;
               end else begin
                  HGrant = sl_oh;
               end
            end
            ST_DATA: begin
               MGnt        = own_oh;
               HSel        = sl_oh;
               HAddress    = own_addr;
               HWrite_data = own_wdata;
               HWrite      = own_write;
               if (sl_ready) begin
                  MDone  = own_oh;
                  MRdata = sl_rdata;
                  MResp  = sl_resp;
               end else if (tmo_hit) begin
                  MDone = own_oh;
                  MResp = 2'b01;
               end
            end
            default: ;
         endcase
      end
   end

   assign Owner = owner_q;

endmodule
